// File: rtl/sel_pkg.sv
// sel_pkg: shared definitions for the pipelined multi-selector.
//   MODE_DIRECT / MODE_WRAP : addressing mode encodings
//   MAX_ADDR_W              : widest per-lane address the helper supports
//   eff_addr()              : effective address and out-of-range flag for one lane
package sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;

    localparam int unsigned MAX_ADDR_W = 16;

    typedef struct packed {
        logic                  oor;
        logic [MAX_ADDR_W-1:0] ea;
    } ea_res_t;

    // Callers zero-extend their narrower address/base into MAX_ADDR_W bits.
    // Operands in range are both < size, so their sum is < 2*size and a single
    // conditional subtract is enough to wrap it.
    function automatic ea_res_t eff_addr(
        input logic [MAX_ADDR_W-1:0] addr,
        input logic [MAX_ADDR_W-1:0] base,
        input logic                  mode,
        input logic [MAX_ADDR_W:0]   size
    );
        ea_res_t             res;
        logic [MAX_ADDR_W:0] sum;
        res.oor = ({1'b0, addr} >= size) || ((mode == MODE_WRAP) && ({1'b0, base} >= size));
        sum     = {1'b0, addr} + {1'b0, base};
        if (mode == MODE_WRAP) begin
            if (sum >= size) begin
                sum = sum - size;
            end
            res.ea = sum[MAX_ADDR_W-1:0];
        end else begin
            res.ea = addr;
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_lane.sv
// sel_lane: one selector lane. Picks entry ea_i out of a flattened SIZE x W
// vector; drives zero when the lane's address is out of range.
//   data_flat_i : entry j at [j*W +: W]
//   ea_i        : effective (already wrapped) address
//   oor_i       : out-of-range flag, forces sel_o to zero
//   sel_o       : selected entry
module sel_lane #(
    parameter int unsigned SIZE   = 16,
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic [W*SIZE-1:0] data_flat_i,
    input  logic [ADDR_W-1:0] ea_i,
    input  logic              oor_i,
    output logic [W-1:0]      sel_o
);

    // Explicit compare-per-entry mux so a non-power-of-two SIZE never indexes
    // past the end of the vector.
    always_comb begin
        sel_o = '0;
        for (int unsigned j = 0; j < SIZE; j++) begin
            if (!oor_i && (ea_i == ADDR_W'(j))) begin
                sel_o = data_flat_i[j*W +: W];
            end
        end
    end

endmodule

// File: rtl/pipelined_multi_selector.sv
// pipelined_multi_selector: K-lane registered selector, two pipeline stages with
// valid/ready handshakes on both sides.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : request handshake
//   addr_flat             : lane i address at [i*ADDR_W +: ADDR_W]
//   data_flat             : entry j at [j*W +: W]
//   base, mode            : base offset; mode 0 = direct, 1 = base-relative wrap
//   out_valid / out_ready : result handshake
//   out_flat              : lane i result at [i*W +: W]
//   out_oor               : lane i address out of range (its result is zero)
//   out_par               : lane i even parity of out_flat lane i
//                           (only when SELECT_PARITY_EN is defined)
// Stage 1 registers the data vector plus per-lane effective address and oor;
// stage 2 registers the muxed lane results.
module pipelined_multi_selector
    import sel_pkg::*;
#(
    parameter int unsigned SIZE = 16,
    parameter int unsigned K    = 4,
    parameter int unsigned W    = 8,
    localparam int unsigned ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W*K-1:0] addr_flat,
    input  logic [W*SIZE-1:0]   data_flat,
    input  logic [ADDR_W-1:0]   base,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W*K-1:0]      out_flat,
    output logic [K-1:0]        out_oor
`ifdef SELECT_PARITY_EN
    ,
    output logic [K-1:0]        out_par
`endif
);

    // Handshake / advance control
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_take, s1_move, accept;

    assign s2_take  = !out_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_take;
    assign in_ready = !s1_valid_q || s2_take;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
        out_valid_d = out_valid_q;
        if (s2_take) begin
            out_valid_d = s1_valid_q;
        end
    end

    // Effective address per lane
    ea_res_t             ea_res [K];
    logic [ADDR_W*K-1:0] ea_d;
    logic [K-1:0]        oor_d;
    logic                unused_ea_hi;

    always_comb begin
        ea_d         = '0;
        oor_d        = '0;
        unused_ea_hi = 1'b0;
        for (int unsigned i = 0; i < K; i++) begin
            ea_res[i] = eff_addr(MAX_ADDR_W'(addr_flat[i*ADDR_W +: ADDR_W]),
                                 MAX_ADDR_W'(base), mode, (MAX_ADDR_W+1)'(SIZE));
            ea_d[i*ADDR_W +: ADDR_W] = ea_res[i].ea[ADDR_W-1:0];
            oor_d[i]                 = ea_res[i].oor;
            // Upper bits are always zero once wrapped; fold them away.
            unused_ea_hi = unused_ea_hi ^ (^ea_res[i].ea[MAX_ADDR_W-1:ADDR_W]);
        end
    end

    // Stage 1 registers
    logic [W*SIZE-1:0]   s1_data_q;
    logic [ADDR_W*K-1:0] s1_ea_q;
    logic [K-1:0]        s1_oor_q;

    // Lane muxes operate on stage-1 contents
    logic [W*K-1:0] lane_flat;

    for (genvar i = 0; i < K; i++) begin : g_lane
        sel_lane #(
            .SIZE   (SIZE),
            .W      (W),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .data_flat_i (s1_data_q),
            .ea_i        (s1_ea_q[i*ADDR_W +: ADDR_W]),
            .oor_i       (s1_oor_q[i]),
            .sel_o       (lane_flat[i*W +: W])
        );
    end

    // Stage 2 registers
    logic [W*K-1:0] out_flat_q;
    logic [K-1:0]   out_oor_q;

`ifdef SELECT_PARITY_EN
    logic [K-1:0] lane_par;
    logic [K-1:0] out_par_q;

    // oor lanes are already zero, so their parity is zero without special casing.
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            lane_par[i] = ^lane_flat[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= '0;
        end else if (s1_move) begin
            out_par_q <= lane_par;
        end
    end

    assign out_par = out_par_q;
`else
    // Parity output not built.
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_ea_q     <= '0;
            s1_oor_q    <= '0;
            out_valid_q <= 1'b0;
            out_flat_q  <= '0;
            out_oor_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                s1_data_q <= data_flat;
                s1_ea_q   <= ea_d;
                s1_oor_q  <= oor_d;
            end
            // Results only change on a stage move, so they hold while stalled.
            if (s1_move) begin
                out_flat_q <= lane_flat;
                out_oor_q  <= s1_oor_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_flat  = out_flat_q;
    assign out_oor   = out_oor_q;

endmodule

// File: tb/tb_pipelined_multi_selector.sv
// Bench for pipelined_multi_selector: one SIZE=16 instance (a_*) and one SIZE=10
// instance (b_*), both K=4, W=8. Expected results come from a behavioural model
// using modulo arithmetic.
module tb_pipelined_multi_selector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
    logic [15:0]  a_addr;
    logic [127:0] a_data;
    logic [3:0]   a_base, a_out_oor;
    logic [31:0]  a_out_flat;

    logic         b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
    logic [15:0]  b_addr;
    logic [79:0]  b_data;
    logic [3:0]   b_base, b_out_oor;
    logic [31:0]  b_out_flat;

`ifdef SELECT_PARITY_EN
    logic [3:0] a_out_par, b_out_par;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] flat;
        logic [3:0]  oor;
        logic [3:0]  par;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    pipelined_multi_selector #(.SIZE(16), .K(4), .W(8)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .addr_flat (a_addr),
        .data_flat (a_data),
        .base      (a_base),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_flat  (a_out_flat),
        .out_oor   (a_out_oor)
`ifdef SELECT_PARITY_EN
        ,
        .out_par   (a_out_par)
`endif
    );

    pipelined_multi_selector #(.SIZE(10), .K(4), .W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .addr_flat (b_addr),
        .data_flat (b_data),
        .base      (b_base),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_flat  (b_out_flat),
        .out_oor   (b_out_oor)
`ifdef SELECT_PARITY_EN
        ,
        .out_par   (b_out_par)
`endif
    );

    // Reference: each lane independently; wrap mode is (addr + base) mod size.
    function automatic exp_t model(input logic [127:0] data, input logic [15:0] addr,
                                   input int base, input bit mode, input int size);
        exp_t e;
        int a, ea;
        e.flat = '0;
        e.oor  = '0;
        e.par  = '0;
        for (int i = 0; i < 4; i++) begin
            a = int'(addr[i*4 +: 4]);
            if (a >= size || (mode && base >= size)) begin
                e.oor[i] = 1'b1;
            end else begin
                ea = mode ? (a + base) % size : a;
                e.flat[i*8 +: 8] = data[ea*8 +: 8];
                e.par[i] = ^data[ea*8 +: 8];
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({a_out_valid, a_out_flat, a_out_oor} !== 37'd0) begin
            errors++;
            $display("FAIL reset_a_outputs: got %h required 0", {a_out_valid, a_out_flat, a_out_oor});
        end
        checks++;
        if ({b_out_valid, b_out_flat, b_out_oor} !== 37'd0) begin
            errors++;
            $display("FAIL reset_b_outputs: got %h required 0", {b_out_valid, b_out_flat, b_out_oor});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b%b required 11", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_direct();
        @(negedge clk);
        for (int j = 0; j < 16; j++) a_data[j*8 +: 8] = 8'(j * 17);
        a_addr = {4'd7, 4'd15, 4'd0, 4'd3};
        a_mode = 1'b0;
        a_base = 4'd0;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL direct_in_ready: got %b required 1", a_in_ready);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL direct_latency_early: out_valid got %b required 0", a_out_valid);
        end
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_flat, a_out_oor} !== {1'b1, 32'h77FF0033, 4'b0000}) begin
            errors++;
            $display("FAIL direct_result: got v=%b flat=%h oor=%b required v=1 flat=77ff0033 oor=0000",
                     a_out_valid, a_out_flat, a_out_oor);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL direct_drain: out_valid got %b required 0", a_out_valid);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        a_addr = {4'd0, 4'd3, 4'd2, 4'd1};
        a_mode = 1'b1;
        a_base = 4'd14;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_flat, a_out_oor} !== {1'b1, 32'hEE1100FF, 4'b0000}) begin
            errors++;
            $display("FAIL wrap_result: got v=%b flat=%h oor=%b required v=1 flat=ee1100ff oor=0000",
                     a_out_valid, a_out_flat, a_out_oor);
        end
        @(negedge clk);
    endtask

    task automatic test_oor();
        logic [15:0] t_addr [3];
        logic [3:0]  t_base [3];
        logic        t_mode [3];
        logic [31:0] t_flat [3];
        logic [3:0]  t_oor  [3];
        t_addr[0] = {4'd0, 4'd15, 4'd10, 4'd9}; t_base[0] = 4'd0;  t_mode[0] = 1'b0;
        t_flat[0] = 32'h00000099;               t_oor[0]  = 4'b0110;
        t_addr[1] = {4'd1, 4'd2, 4'd3, 4'd4};   t_base[1] = 4'd12; t_mode[1] = 1'b1;
        t_flat[1] = 32'h00000000;               t_oor[1]  = 4'b1111;
        t_addr[2] = {4'd9, 4'd3, 4'd2, 4'd5};   t_base[2] = 4'd7;  t_mode[2] = 1'b1;
        t_flat[2] = 32'h66009922;               t_oor[2]  = 4'b0000;
        b_out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            for (int j = 0; j < 10; j++) b_data[j*8 +: 8] = 8'(j * 17);
            b_addr = t_addr[t];
            b_base = t_base[t];
            b_mode = t_mode[t];
            b_in_valid = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({b_out_valid, b_out_flat, b_out_oor} !== {1'b1, t_flat[t], t_oor[t]}) begin
                errors++;
                $display("FAIL oor_case%0d: got v=%b flat=%h oor=%b required v=1 flat=%h oor=%b",
                         t, b_out_valid, b_out_flat, b_out_oor, t_flat[t], t_oor[t]);
            end
        end
        @(negedge clk);
    endtask

`ifdef SELECT_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        a_data = '0;
        a_data[7:0]  = 8'h07;
        a_data[15:8] = 8'h03;
        a_addr = {4'd1, 4'd0, 4'd1, 4'd0};
        a_mode = 1'b0;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_par} !== {1'b1, 4'b0101}) begin
            errors++;
            $display("FAIL parity: got v=%b par=%b required v=1 par=0101", a_out_valid, a_out_par);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] held;
        bit   have_held = 0;
        int   sent = 0;
        int   got = 0;
        exp_t e;
        qa.delete();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            a_in_valid = (sent < 8);
            a_data = {$urandom, $urandom, $urandom, $urandom};
            a_addr = 16'($urandom);
            a_base = 4'($urandom);
            a_mode = 1'($urandom);
            a_out_ready = (cyc >= 4);
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_in_ready_cyc%0d: got %b required 0", cyc, a_in_ready);
                end
            end
            if (a_out_valid && !a_out_ready) begin
                if (have_held) begin
                    checks++;
                    if (a_out_flat !== held) begin
                        errors++;
                        $display("FAIL b2b_stall_hold: got %h required %h", a_out_flat, held);
                    end
                end
                held = a_out_flat;
                have_held = 1;
            end else begin
                have_held = 0;
            end
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_output: got flat=%h required none", a_out_flat);
                end else begin
                    e = qa.pop_front();
                    got++;
                    if ({a_out_flat, a_out_oor} !== {e.flat, e.oor}) begin
                        errors++;
                        $display("FAIL b2b_result%0d: got %h/%b required %h/%b",
                                 got, a_out_flat, a_out_oor, e.flat, e.oor);
                    end
                end
            end
            if (a_in_valid && a_in_ready) begin
                qa.push_back(model(a_data, a_addr, int'(a_base), a_mode, 16));
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        checks++;
        if (got != 8 || sent != 8) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d received=%0d required 8/8", sent, got);
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit draining;
            draining = (cyc >= 300);
            if (draining && qa.size() == 0 && qb.size() == 0) break;
            a_in_valid  = !draining && ($urandom_range(0, 3) != 0);
            a_out_ready = draining || ($urandom_range(0, 3) != 0);
            a_data = {$urandom, $urandom, $urandom, $urandom};
            a_addr = 16'($urandom);
            a_base = 4'($urandom);
            a_mode = 1'($urandom);
            b_in_valid  = !draining && ($urandom_range(0, 2) != 0);
            b_out_ready = draining || ($urandom_range(0, 2) != 0);
            b_data = {$urandom, $urandom, 16'($urandom)};
            b_addr = 16'($urandom);
            b_base = 4'($urandom_range(0, 11));
            b_mode = 1'($urandom);
            #1;
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL rand_a_extra: got flat=%h required none", a_out_flat);
                end else begin
                    e = qa.pop_front();
                    if ({a_out_flat, a_out_oor} !== {e.flat, e.oor}) begin
                        errors++;
                        $display("FAIL rand_a_result: got %h/%b required %h/%b",
                                 a_out_flat, a_out_oor, e.flat, e.oor);
                    end
`ifdef SELECT_PARITY_EN
                    if (a_out_par !== e.par) begin
                        errors++;
                        $display("FAIL rand_a_par: got %b required %b", a_out_par, e.par);
                    end
`endif
                end
            end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_b_extra: got flat=%h required none", b_out_flat);
                end else begin
                    e = qb.pop_front();
                    if ({b_out_flat, b_out_oor} !== {e.flat, e.oor}) begin
                        errors++;
                        $display("FAIL rand_b_result: got %h/%b required %h/%b",
                                 b_out_flat, b_out_oor, e.flat, e.oor);
                    end
`ifdef SELECT_PARITY_EN
                    if (b_out_par !== e.par) begin
                        errors++;
                        $display("FAIL rand_b_par: got %b required %b", b_out_par, e.par);
                    end
`endif
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(model(a_data, a_addr, int'(a_base), a_mode, 16));
            if (b_in_valid && b_in_ready) qb.push_back(model({48'd0, b_data}, b_addr, int'(b_base), b_mode, 10));
            @(posedge clk);
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got pending a=%0d b=%0d required 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        a_out_ready = 1'b0;
        a_data = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        a_addr = 16'h0000;
        a_mode = 1'b0;
        a_in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_precond: out_valid got %b required 1", a_out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_out_flat, a_out_oor} !== 37'd0) begin
            errors++;
            $display("FAIL midreset_async_clear: got %h required 0", {a_out_valid, a_out_flat, a_out_oor});
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale_c%0d: out_valid got %b required 0", c, a_out_valid);
            end
        end
    endtask

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_mode = 1'b0;
        a_addr = '0; a_data = '0; a_base = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_mode = 1'b0;
        b_addr = '0; b_data = '0; b_base = '0;
        test_reset();
        test_direct();
        test_wrap();
        test_oor();
`ifdef SELECT_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
